// File: rtl/maze_walk_controller.sv
// maze_walk_controller
// Per-frame sequencer for the maze path-finder agent. Runs datapath
// calibration, then probes the window/edge datapath once per video frame and
// moves the agent one step per frame according to the open-direction report.
//
// Ports
//   clk, reset          system clock, asynchronous active-low reset
//   mode[1:0]           00 idle, 01 run, 10 pause, 11 restart
//   video_frame_valid   high during the active frame
//   params_valid        calibration result strobe (start/end coordinates)
//   start_x/y, end_x/y  calibration result, 10 bits each
//   step_valid          probe answer strobe
//   step_dirs[3:0]      open directions {down,left,up,right}
//   calib_en            datapath calibration enable
//   probe_req           one-cycle probe request at the current pose
//   cur_x/y, cur_dir    agent pose and one-hot heading
//   state[2:0]          controller state (see table below)
//   goal_reached, lost  sticky status flags
//   frame_cnt[9:0]      frames spent in TRACK, wraps
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for run mode
// CALIB | datapath calibrating; counting consecutive frames with params
// ARM   | one cycle: load start pose, validate start/end coordinates
// TRACK | probe each frame, step the agent at each frame end
// DONE  | goal captured (terminal until idle/restart)
// LOST  | bad coordinates, dead end, wall hit or probe timeout (terminal)

module maze_walk_controller #(
  parameter int STEP_H         = 8,
  parameter int STEP_V         = 4,
  parameter int MAX_X          = 701,
  parameter int MAX_Y          = 287,
  parameter int GOAL_TOL       = 6,
  parameter int CALIB_FRAMES   = 3,
  parameter int TIMEOUT_FRAMES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic       video_frame_valid,
  input  logic       params_valid,
  input  logic [9:0] start_x,
  input  logic [9:0] start_y,
  input  logic [9:0] end_x,
  input  logic [9:0] end_y,
  input  logic       step_valid,
  input  logic [3:0] step_dirs,
  output logic       calib_en,
  output logic       probe_req,
  output logic [9:0] cur_x,
  output logic [9:0] cur_y,
  output logic [3:0] cur_dir,
  output logic [2:0] state,
  output logic       goal_reached,
  output logic       lost,
  output logic [9:0] frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CALIB = 3'd1,
    S_ARM   = 3'd2,
    S_TRACK = 3'd3,
    S_DONE  = 3'd4,
    S_LOST  = 3'd5
  } state_t;

  localparam logic signed [10:0] SH     = 11'(STEP_H);
  localparam logic signed [10:0] SV     = 11'(STEP_V);
  localparam logic signed [10:0] MXS    = 11'(MAX_X);
  localparam logic signed [10:0] MYS    = 11'(MAX_Y);
  localparam logic signed [10:0] TOL    = 11'(GOAL_TOL);
  localparam logic [9:0]         MAXX_U = 10'(MAX_X);
  localparam logic [9:0]         MAXY_U = 10'(MAX_Y);
  localparam logic [3:0]         CAL_N  = 4'(CALIB_FRAMES);
  localparam logic [3:0]         TO_N   = 4'(TIMEOUT_FRAMES);

  state_t     state_q, state_d;
  logic       vfv_ok_q, vfv_ok_d;
  logic       vfv_q, vfv_d;
  logic       fs_q, fs_d;
  logic       fe_q, fe_d;
  logic [3:0] cal_cnt_q, cal_cnt_d;
  logic [3:0] miss_cnt_q, miss_cnt_d;
  logic       params_seen_q, params_seen_d;
  logic       outstanding_q, outstanding_d;
  logic       answered_q, answered_d;
  logic [3:0] dirs_q, dirs_d;
  logic [9:0] sx_q, sx_d, sy_q, sy_d, ex_q, ex_d, ey_q, ey_d;
  logic [9:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [3:0] cur_dir_q, cur_dir_d;
  logic       goal_q, goal_d;
  logic       lost_q, lost_d;
  logic [9:0] frame_cnt_q, frame_cnt_d;

  // Direction choice and candidate pose for the current frame end.
  logic [3:0]        rev, dirs_use, cand, new_dir;
  logic              dead, step_take, oob, at_goal;
  logic signed [10:0] x_s, y_s, nx, ny, dx, dy, adx, ady;

  always_comb begin
    rev       = {cur_dir_q[1], cur_dir_q[0], cur_dir_q[3], cur_dir_q[2]};
    step_take = step_valid && outstanding_q;
    // An answer coinciding with frame end is used for that same frame.
    dirs_use  = step_take ? step_dirs : dirs_q;
    cand      = dirs_use & ~rev;
    dead      = (dirs_use == 4'b0000);
    if ((cur_dir_q & cand) != 4'b0000) new_dir = cur_dir_q;
    else if (cand[3])                   new_dir = 4'b1000;
    else if (cand[2])                   new_dir = 4'b0100;
    else if (cand[1])                   new_dir = 4'b0010;
    else if (cand[0])                   new_dir = 4'b0001;
    else                                new_dir = rev;

    x_s = signed'({1'b0, cur_x_q});
    y_s = signed'({1'b0, cur_y_q});
    nx  = x_s;
    ny  = y_s;
    case (new_dir)
      4'b1000: ny = y_s + SV;
      4'b0100: nx = x_s - SH;
      4'b0010: ny = y_s - SV;
      4'b0001: nx = x_s + SH;
      default: ;
    endcase
    oob = (nx < 11'sd0) || (nx > MXS) || (ny < 11'sd0) || (ny > MYS);

    dx      = nx - signed'({1'b0, ex_q});
    dy      = ny - signed'({1'b0, ey_q});
    adx     = (dx < 11'sd0) ? -dx : dx;
    ady     = (dy < 11'sd0) ? -dy : dy;
    at_goal = (adx <= TOL) && (ady <= TOL);
  end

  always_comb begin
    // The first cycle after reset only loads vfv_q, so a frame that is
    // already high is not taken as a frame start.
    vfv_ok_d      = 1'b1;
    vfv_d         = video_frame_valid;
    fs_d          = vfv_ok_q & video_frame_valid & ~vfv_q;
    fe_d          = vfv_ok_q & ~video_frame_valid & vfv_q;
    state_d       = state_q;
    cal_cnt_d     = cal_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    params_seen_d = params_seen_q;
    outstanding_d = outstanding_q;
    answered_d    = answered_q;
    dirs_d        = dirs_q;
    sx_d          = sx_q;
    sy_d          = sy_q;
    ex_d          = ex_q;
    ey_d          = ey_q;
    cur_x_d       = cur_x_q;
    cur_y_d       = cur_y_q;
    cur_dir_d     = cur_dir_q;
    goal_d        = goal_q;
    lost_d        = lost_q;
    frame_cnt_d   = frame_cnt_q;

    case (mode)
      2'b00: state_d = S_IDLE;
      2'b11: begin
        state_d       = S_CALIB;
        goal_d        = 1'b0;
        lost_d        = 1'b0;
        frame_cnt_d   = 10'd0;
        cal_cnt_d     = 4'd0;
        miss_cnt_d    = 4'd0;
        params_seen_d = 1'b0;
        outstanding_d = 1'b0;
        answered_d    = 1'b0;
      end
      2'b10: ;
      default: begin
        case (state_q)
          S_IDLE: begin
            state_d       = S_CALIB;
            cal_cnt_d     = 4'd0;
            params_seen_d = 1'b0;
          end
          S_CALIB: begin
            if (params_valid) begin
              sx_d          = start_x;
              sy_d          = start_y;
              ex_d          = end_x;
              ey_d          = end_y;
              params_seen_d = 1'b1;
            end
            if (fe_q) begin
              params_seen_d = 1'b0;
              if (params_seen_q || params_valid) begin
                cal_cnt_d = cal_cnt_q + 4'd1;
                if (cal_cnt_q + 4'd1 >= CAL_N) state_d = S_ARM;
              end else begin
                cal_cnt_d = 4'd0;
              end
            end
          end
          S_ARM: begin
            cur_x_d       = sx_q;
            cur_y_d       = sy_q;
            cur_dir_d     = 4'b1000;
            frame_cnt_d   = 10'd0;
            miss_cnt_d    = 4'd0;
            outstanding_d = 1'b0;
            answered_d    = 1'b0;
            if ((sx_q > MAXX_U) || (sy_q > MAXY_U) ||
                (ex_q > MAXX_U) || (ey_q > MAXY_U)) begin
              state_d = S_LOST;
              lost_d  = 1'b1;
            end else begin
              state_d = S_TRACK;
            end
          end
          S_TRACK: begin
            if (step_take) begin
              dirs_d        = step_dirs;
              answered_d    = 1'b1;
              outstanding_d = 1'b0;
            end
            if (fs_q) outstanding_d = 1'b1;
            if (fe_q) begin
              frame_cnt_d   = frame_cnt_q + 10'd1;
              outstanding_d = 1'b0;
              answered_d    = 1'b0;
              if (outstanding_q && !step_valid) begin
                miss_cnt_d = miss_cnt_q + 4'd1;
                if (miss_cnt_q + 4'd1 >= TO_N) begin
                  state_d = S_LOST;
                  lost_d  = 1'b1;
                end
              end else if (step_take || answered_q) begin
                miss_cnt_d = 4'd0;
                if (dead) begin
                  state_d = S_LOST;
                  lost_d  = 1'b1;
                end else begin
                  cur_dir_d = new_dir;
                  if (oob) begin
                    state_d = S_LOST;
                    lost_d  = 1'b1;
                  end else begin
                    cur_x_d = nx[9:0];
                    cur_y_d = ny[9:0];
                    if (at_goal) begin
                      state_d = S_DONE;
                      goal_d  = 1'b1;
                    end
                  end
                end
              end
            end
          end
          S_DONE, S_LOST: ;
          default: state_d = S_IDLE;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      vfv_ok_q      <= 1'b0;
      vfv_q         <= 1'b0;
      fs_q          <= 1'b0;
      fe_q          <= 1'b0;
      cal_cnt_q     <= 4'd0;
      miss_cnt_q    <= 4'd0;
      params_seen_q <= 1'b0;
      outstanding_q <= 1'b0;
      answered_q    <= 1'b0;
      dirs_q        <= 4'd0;
      sx_q          <= 10'd0;
      sy_q          <= 10'd0;
      ex_q          <= 10'd0;
      ey_q          <= 10'd0;
      cur_x_q       <= 10'd0;
      cur_y_q       <= 10'd0;
      cur_dir_q     <= 4'b1000;
      goal_q        <= 1'b0;
      lost_q        <= 1'b0;
      frame_cnt_q   <= 10'd0;
    end else begin
      state_q       <= state_d;
      vfv_ok_q      <= vfv_ok_d;
      vfv_q         <= vfv_d;
      fs_q          <= fs_d;
      fe_q          <= fe_d;
      cal_cnt_q     <= cal_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      params_seen_q <= params_seen_d;
      outstanding_q <= outstanding_d;
      answered_q    <= answered_d;
      dirs_q        <= dirs_d;
      sx_q          <= sx_d;
      sy_q          <= sy_d;
      ex_q          <= ex_d;
      ey_q          <= ey_d;
      cur_x_q       <= cur_x_d;
      cur_y_q       <= cur_y_d;
      cur_dir_q     <= cur_dir_d;
      goal_q        <= goal_d;
      lost_q        <= lost_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign calib_en     = (state_q == S_CALIB);
  assign probe_req    = fs_q && (state_q == S_TRACK) && (mode == 2'b01);
  assign cur_x        = cur_x_q;
  assign cur_y        = cur_y_q;
  assign cur_dir      = cur_dir_q;
  assign state        = state_q;
  assign goal_reached = goal_q;
  assign lost         = lost_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_maze_walk_controller.sv
// Testbench for maze_walk_controller: frame-level reference model with a
// queue of expected snapshots, checked by an independent monitor at each
// frame end (two cycles after the frame falls) or on an explicit snapshot.

module tb_maze_walk_controller;

  localparam int ST_IDLE = 0, ST_CALIB = 1, ST_ARM = 2, ST_TRACK = 3,
                 ST_DONE = 4, ST_LOST = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic       video_frame_valid;
  logic       params_valid;
  logic [9:0] start_x, start_y, end_x, end_y;
  logic       step_valid;
  logic [3:0] step_dirs;
  logic       calib_en, probe_req;
  logic [9:0] cur_x, cur_y;
  logic [3:0] cur_dir;
  logic [2:0] state;
  logic       goal_reached, lost;
  logic [9:0] frame_cnt;

  always #5 clk = ~clk;

  maze_walk_controller dut (
    .clk(clk), .reset(reset), .mode(mode),
    .video_frame_valid(video_frame_valid), .params_valid(params_valid),
    .start_x(start_x), .start_y(start_y), .end_x(end_x), .end_y(end_y),
    .step_valid(step_valid), .step_dirs(step_dirs),
    .calib_en(calib_en), .probe_req(probe_req),
    .cur_x(cur_x), .cur_y(cur_y), .cur_dir(cur_dir), .state(state),
    .goal_reached(goal_reached), .lost(lost), .frame_cnt(frame_cnt)
  );

  typedef struct {
    bit is_frame;
    int st, x, y, dir, goal, lst, fc, probes;
  } exp_t;

  exp_t expq[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   chk_idx = 0;
  bit   snap_req = 1'b0;

  // Reference model state (heading as index: 3 down, 2 left, 1 up, 0 right)
  int m_st, m_x, m_y, m_dir, m_goal, m_lost, m_fc, m_cal, m_miss;
  int m_sx, m_sy, m_ex, m_ey, m_mode;

  function automatic void cmp(string nm, int got, int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s (check %0d): got %0d, want %0d", nm, chk_idx, got, want);
    end
  endfunction

  function automatic void do_check(bit is_frame, int pc);
    exp_t e;
    chk_idx++;
    if (expq.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL queue_empty (check %0d): got no expectation, want one", chk_idx);
      return;
    end
    e = expq.pop_front();
    cmp("kind", int'(is_frame), int'(e.is_frame));
    cmp("state", int'(state), e.st);
    cmp("cur_x", int'(cur_x), e.x);
    cmp("cur_y", int'(cur_y), e.y);
    cmp("cur_dir", int'(cur_dir), e.dir);
    cmp("goal_reached", int'(goal_reached), e.goal);
    cmp("lost", int'(lost), e.lst);
    cmp("frame_cnt", int'(frame_cnt), e.fc);
    cmp("calib_en", int'(calib_en), (e.st == ST_CALIB) ? 1 : 0);
    if (is_frame) cmp("probe_count", pc, e.probes);
  endfunction

  // Monitor: independent of stimulus; counts probes, checks at frame end + 2.
  initial begin
    int cd = 0;
    int pcnt = 0;
    bit prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (probe_req) pcnt++;
      if (snap_req) begin
        do_check(1'b0, pcnt);
        pcnt = 0;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          do_check(1'b1, pcnt);
          pcnt = 0;
        end
      end
      if (prev_v && !video_frame_valid) cd = 2;
      prev_v = video_frame_valid;
    end
  end

  function automatic void push_exp(bit is_frame, int probes);
    exp_t e;
    e.is_frame = is_frame;
    e.st = m_st; e.x = m_x; e.y = m_y; e.dir = 1 << m_dir;
    e.goal = m_goal; e.lst = m_lost; e.fc = m_fc; e.probes = probes;
    expq.push_back(e);
  endfunction

  function automatic void model_reset();
    m_st = ST_IDLE; m_x = 0; m_y = 0; m_dir = 3; m_goal = 0; m_lost = 0;
    m_fc = 0; m_cal = 0; m_miss = 0; m_sx = 0; m_sy = 0; m_ex = 0; m_ey = 0;
    m_mode = 0;
  endfunction

  function automatic int pick(int cur, logic [3:0] d);
    int rv = (cur + 2) % 4;
    logic [3:0] cand = d;
    cand[rv] = 1'b0;
    if (cand[cur]) return cur;
    for (int i = 3; i >= 0; i--) if (cand[i]) return i;
    if (d[rv]) return rv;
    return -1;
  endfunction

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic void go_lost();
    m_st = ST_LOST;
    m_lost = 1;
  endfunction

  function automatic void resolve_arm();
    m_x = m_sx; m_y = m_sy; m_dir = 3; m_fc = 0; m_miss = 0;
    if (m_sx > 701 || m_sy > 287 || m_ex > 701 || m_ey > 287) go_lost();
    else m_st = ST_TRACK;
  endfunction

  // Frame-level effect of one frame on the model; ans 0 none, 1 in-frame, 2 at frame end.
  function automatic int model_frame(bit pv, int ans, logic [3:0] d);
    int probes = (m_st == ST_TRACK && m_mode == 1) ? 1 : 0;
    int nd, nx, ny;
    if (m_mode == 1) begin
      if (m_st == ST_CALIB) begin
        if (pv) begin
          m_sx = int'(start_x); m_sy = int'(start_y);
          m_ex = int'(end_x);   m_ey = int'(end_y);
          m_cal++;
          if (m_cal >= 3) m_st = ST_ARM;
        end else m_cal = 0;
      end else if (m_st == ST_TRACK) begin
        m_fc = (m_fc + 1) % 1024;
        if (ans == 0) begin
          m_miss++;
          if (m_miss >= 4) go_lost();
        end else begin
          m_miss = 0;
          nd = pick(m_dir, d);
          if (nd < 0) go_lost();
          else begin
            m_dir = nd;
            nx = m_x; ny = m_y;
            case (nd)
              3: ny = ny + 4;
              2: nx = nx - 8;
              1: ny = ny - 4;
              default: nx = nx + 8;
            endcase
            if (nx < 0 || nx > 701 || ny < 0 || ny > 287) go_lost();
            else begin
              m_x = nx; m_y = ny;
              if (iabs(nx - m_ex) <= 6 && iabs(ny - m_ey) <= 6) begin
                m_st = ST_DONE;
                m_goal = 1;
              end
            end
          end
        end
      end
    end
    return probes;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    push_exp(1'b0, 0);
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
  endtask

  task automatic set_mode(logic [1:0] m);
    tick();
    mode = m;
    m_mode = int'(m);
    case (m)
      2'b00: m_st = ST_IDLE;
      2'b11: begin
        m_st = ST_CALIB; m_goal = 0; m_lost = 0; m_fc = 0; m_cal = 0; m_miss = 0;
      end
      2'b01: if (m_st == ST_IDLE) begin m_st = ST_CALIB; m_cal = 0; end
      default: ;
    endcase
    tick();
  endtask

  task automatic frame(bit pv, int ans, logic [3:0] d, bit spur);
    int probes;
    bit sp = spur && (ans == 1);
    probes = model_frame(pv, ans, d);
    push_exp(1'b1, probes);
    if (m_st == ST_ARM) resolve_arm();
    video_frame_valid = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      params_valid = pv && (c == 4);
      step_valid   = (ans == 1 && c == 3) || (sp && c == 6);
      step_dirs    = (c == 6) ? ~d : d;
    end
    video_frame_valid = 1'b0;
    tick();
    step_valid = (ans == 2);
    step_dirs  = d;
    tick();
    step_valid = 1'b0;
    repeat (2 + $urandom_range(3, 0)) tick();
  endtask

  task automatic calib(int x0, int y0, int x1, int y1);
    start_x = 10'(x0); start_y = 10'(y0); end_x = 10'(x1); end_y = 10'(y1);
    repeat (3) frame(1'b1, 0, 4'b0000, 1'b0);
  endtask

  task automatic restart();
    set_mode(2'b11);
    set_mode(2'b01);
  endtask

  initial begin
    int fr;
    logic [3:0] rd;
    int ra;
    reset = 1'b0; mode = 2'b00; video_frame_valid = 1'b0; params_valid = 1'b0;
    start_x = '0; start_y = '0; end_x = '0; end_y = '0;
    step_valid = 1'b0; step_dirs = 4'b0000;
    model_reset();
    tick(); tick();
    snap();
    reset = 1'b1;
    tick();
    frame(1'b0, 0, 4'b0000, 1'b0);

    // Calibration and straight run
    set_mode(2'b01);
    snap();
    calib(351, 60, 351, 275);
    repeat (3) frame(1'b0, 1, 4'b1010, 1'b0);

    // Turn, dead-end turn-back (with an ignored extra answer), answer at frame end
    frame(1'b0, 1, 4'b0110, 1'b0);
    frame(1'b0, 1, 4'b0001, 1'b1);
    frame(1'b0, 2, 4'b1000, 1'b0);

    // Pause for two frames, then resume
    set_mode(2'b10);
    repeat (2) frame(1'b0, 0, 4'b0000, 1'b0);
    set_mode(2'b01);
    frame(1'b0, 1, 4'b1000, 1'b0);

    // Probe timeout, then terminal LOST
    repeat (4) frame(1'b0, 0, 4'b0000, 1'b0);
    frame(1'b0, 1, 4'b1000, 1'b0);

    // Restart clears flags; goal capture then frozen
    set_mode(2'b11);
    snap();
    set_mode(2'b01);
    calib(351, 64, 351, 70);
    frame(1'b0, 1, 4'b1000, 1'b0);
    frame(1'b0, 1, 4'b1000, 1'b0);

    // Wall hit on the left edge
    restart();
    calib(4, 100, 600, 200);
    frame(1'b0, 1, 4'b0100, 1'b0);

    // Start outside the maze is rejected at ARM
    restart();
    calib(800, 100, 600, 200);
    frame(1'b0, 1, 4'b1000, 1'b0);

    // No open direction, then idle keeps flags
    restart();
    calib(100, 100, 600, 200);
    frame(1'b0, 1, 4'b0000, 1'b0);
    set_mode(2'b00);
    snap();

    // Randomized walks
    for (int run = 0; run < 6; run++) begin
      restart();
      start_x = 10'($urandom_range(690, 10));
      start_y = 10'($urandom_range(280, 8));
      end_x   = 10'($urandom_range(701, 0));
      end_y   = 10'($urandom_range(287, 0));
      fr = 0;
      while (m_st == ST_CALIB && fr < 10) begin
        frame($urandom_range(3, 0) != 0, 0, 4'b0000, 1'b0);
        fr++;
      end
      fr = 0;
      while (m_st == ST_TRACK && fr < 30) begin
        rd = 4'($urandom_range(15, 0));
        ra = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(2, 1));
        frame(1'b0, ra, rd, 1'($urandom_range(1, 0)));
        fr++;
      end
    end

    // Asynchronous reset in the middle of a TRACK frame
    restart();
    calib(200, 100, 600, 200);
    frame(1'b0, 1, 4'b1000, 1'b0);
    video_frame_valid = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    mode = 2'b00;
    model_reset();
    snap();
    push_exp(1'b1, 0);
    tick();
    video_frame_valid = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    repeat (8) tick();

    if (expq.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL leftover_expectations: got %0d unchecked, want 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/maze_walk_controller.md
# maze_walk_controller

Per-frame sequencer for the maze path-finder agent. Owns the agent pose and heading, drives the calibration and probe phases of the window/edge datapath, and advances the agent by one step per video frame from the datapath's possible-direction report. Sits between the video timing signals and the scan-window datapath, and feeds pose and status to the overlay drawing logic.

## Interface
- STEP_H, 8: horizontal step in pixels per frame
- STEP_V, 4: vertical step in lines per frame
- MAX_X, 701: last valid pixel column
- MAX_Y, 287: last valid line
- GOAL_TOL, 6: goal capture tolerance per axis, in pixels
- CALIB_FRAMES, 3: consecutive frames with valid parameters required to arm
- TIMEOUT_FRAMES, 4: consecutive unanswered probes in TRACK before LOST

- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- mode  in  2  00 idle, 01 run, 10 pause, 11 restart
- video_frame_valid  in  1  high during active frame
- params_valid  in  1  one-cycle pulse: calibration produced start/end this frame
- start_x, start_y, end_x, end_y  in  10 each  calibration result, sampled on params_valid
- step_valid  in  1  one-cycle pulse: probe answer
- step_dirs  in  4  open directions {down,left,up,right}, sampled on step_valid
- calib_en  out  1  enables datapath calibration
- probe_req  out  1  one-cycle probe request at the current pose
- cur_x, cur_y  out  10 each  agent pose
- cur_dir  out  4  one-hot heading, same bit order as step_dirs
- state  out  3  0 IDLE, 1 CALIB, 2 ARM, 3 TRACK, 4 DONE, 5 LOST
- goal_reached, lost  out  1 each  sticky status flags
- frame_cnt  out  10  frames spent in TRACK; wraps 1023 -> 0

## Operation
- Reset values: state IDLE, all outputs 0, except cur_dir = 4'b1000 (down).
- frame_start is the rising edge of video_frame_valid; frame_end is the falling edge. Both are detected with one register stage.
- mode 00: go to IDLE the next cycle from any state. Status flags are held.
- mode 11: go to CALIB the next cycle. Clears goal_reached, lost, frame_cnt, and the calibration and timeout counters.
- mode 10: freeze the state, pose and counters. No probe_req and no pose update. Flags stay visible.
- IDLE -> CALIB when mode is 01.
- CALIB: calib_en = 1.
  - At each frame_end, increment the calibration count if params_valid was seen during that frame; otherwise clear it.
  - Latch the last start/end values received.
  - Reaching CALIB_FRAMES -> ARM.
- ARM: lasts one cycle.
  - Set cur_x/cur_y to the latched start, cur_dir to down, frame_cnt to 0.
  - Reject the run -> LOST if the start or end lies outside MAX_X/MAX_Y.
  - Otherwise -> TRACK.
- TRACK: on each frame_start, pulse probe_req and set the outstanding flag.
  - A step_valid arriving while outstanding latches step_dirs and clears outstanding.
  - Other step_valid pulses are ignored.
- Direction choice at frame_end:
  - reverse = {cur_dir[1], cur_dir[0], cur_dir[3], cur_dir[2]}.
  - cand = dirs & ~reverse.
  - If cur_dir is in cand, keep it. Otherwise pick the highest set bit of cand (priority down > left > up > right).
  - If cand is 0 but dirs equals reverse, turn back (dead end).
  - If dirs is 0 -> LOST.
- Pose update: down y+STEP_V, up y-STEP_V, left x-STEP_H, right x+STEP_H.
  - Compute in 11-bit signed arithmetic.
  - A result < 0 or > MAX -> LOST, and the pose is held at its last legal value.
- Goal: after the update, if |x-end_x| <= GOAL_TOL and |y-end_y| <= GOAL_TOL -> DONE, with goal_reached = 1.
- Timeout: a frame_end with the probe still outstanding increments the miss count and leaves the pose unchanged. Reaching TIMEOUT_FRAMES -> LOST with lost = 1. Any answered frame clears the miss count.
- DONE and LOST are terminal until mode 00 or 11.

## Timing
- probe_req is high on the cycle after video_frame_valid rises.
- The pose, cur_dir and state update on the cycle after frame_end is detected, i.e. 2 cycles after video_frame_valid falls.
- frame_cnt increments in that same cycle.
- If step_valid and frame_end coincide, the answer is accepted and used for that frame's update.
- A frame already in progress on entry to TRACK produces no probe; the first probe is at the next frame_start.
- If mode changes in the same cycle as frame_end, the mode transition wins and no pose update occurs.
- Asynchronous reset mid-frame returns to the reset values immediately. Edge detectors reset to 0, so a frame that is already high is not seen as a frame_start.

## Test plan
- Calibration: mode 01, 3 frames each with params_valid (start 351,60; end 351,275) -> ARM then TRACK; cur_x=351, cur_y=60, cur_dir=1000.
- Straight run: step_dirs=1010 every frame -> cur_y advances 60, 64, 68 …; cur_dir stays 1000; probe_req exactly once per frame.
- Turn and reverse exclusion: heading down, step_dirs=0110 -> cur_dir=0100, cur_x-=8. Then step_dirs=0001 only (reverse of left) -> turn back to 0001.
- Goal: end at (351,70), pose at (351,64), dirs 1000 -> y=68 within tolerance -> state DONE, goal_reached=1, pose frozen on later frames.
- Timeout and bounds: 4 frames with no step_valid -> LOST, lost=1. Separately, pose x=4 heading left -> x would go to -4 -> LOST, x stays 4.
- Control: mode 10 mid-TRACK for 2 frames -> no probe_req, pose unchanged; mode 11 -> CALIB with flags cleared; async reset mid-frame -> all outputs at reset values.
